// File: rtl/rsqrt_nr_job_scheduler.sv
// Round-robin job scheduler sharing one iterative Newton-Raphson rsqrt datapath.
// Runs ITERATION+1 passes per job and returns the final estimate tagged with its requester.
module rsqrt_nr_job_scheduler #(
  parameter int unsigned WL        = 24,
  parameter int unsigned NREQ      = 4,
  parameter int unsigned IDW       = 2,
  parameter int unsigned ITERATION = 1,
  parameter int unsigned PASS_LAT  = 3
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*WL-1:0]   req_data,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [WL-1:0]        rsp_data,
  output logic [IDW-1:0]       rsp_id,
  output logic                 rsp_err,
  output logic                 dp_ce,
  output logic                 dp_start,
  output logic                 dp_sel,
  output logic [WL-1:0]        dp_x,
  output logic [WL-1:0]        dp_fb,
  input  logic [WL-1:0]        dp_y,
  output logic                 busy
);

  localparam int unsigned PCW = (ITERATION > 0) ? $clog2(ITERATION + 1) : 1;
  localparam int unsigned WCW = (PASS_LAT > 1) ? $clog2(PASS_LAT) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]     state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [PCW-1:0] pass_q, pass_d;
  logic [WCW-1:0] wait_q, wait_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic [WL-1:0]  rsp_data_q, rsp_data_d;
  logic [IDW-1:0] rsp_id_q, rsp_id_d;
  logic           rsp_err_q, rsp_err_d;
  logic           dp_ce_q, dp_ce_d;
  logic           dp_start_q, dp_start_d;
  logic           dp_sel_q, dp_sel_d;
  logic [WL-1:0]  dp_x_q, dp_x_d;
  logic [WL-1:0]  dp_fb_q, dp_fb_d;
  logic           busy_q, busy_d;

  logic [WL-1:0]  req_op [NREQ];
  logic           grant_found;
  logic [IDW-1:0] grant_idx;

  function automatic logic [IDW-1:0] idx_add(input logic [IDW-1:0] base, input int unsigned off);
    int unsigned sum;
    sum = 32'(base) + off;
    return IDW'(sum % NREQ);
  endfunction

  for (genvar g = 0; g < NREQ; g++) begin : g_op
    assign req_op[g] = req_data[g*WL +: WL];
  end

  // First valid requester at or above the pointer, wrapping around.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!grant_found && req_valid[idx_add(ptr_q, i)]) begin
        grant_found = 1'b1;
        grant_idx   = idx_add(ptr_q, i);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    pass_d     = pass_q;
    wait_d     = wait_q;
    rsp_data_d = rsp_data_q;
    rsp_id_d   = rsp_id_q;
    rsp_err_d  = rsp_err_q;
    dp_sel_d   = dp_sel_q;
    dp_x_d     = dp_x_q;
    dp_fb_d    = dp_fb_q;
    req_ready  = '0;

    case (state_q)
      S_IDLE: begin
        if (grant_found && !RST) begin
          req_ready[grant_idx] = 1'b1;
          dp_x_d   = req_op[grant_idx];
          rsp_id_d = grant_idx;
          ptr_d    = idx_add(grant_idx, 1);
          pass_d   = '0;
          // Unnormalised operand bypasses the datapath entirely.
          if (!req_op[grant_idx][WL-1]) begin
            rsp_data_d = '1;
            rsp_err_d  = 1'b1;
            state_d    = S_RESP;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        wait_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        wait_d = wait_q + WCW'(1);
        if (wait_q == WCW'(PASS_LAT - 1)) begin
          dp_fb_d = dp_y;
          if (pass_q == PCW'(ITERATION)) begin
            rsp_data_d = dp_y;
            rsp_err_d  = 1'b0;
            state_d    = S_RESP;
          end else begin
            pass_d  = pass_q + PCW'(1);
            state_d = S_ISSUE;
          end
        end
      end
      default: begin
        if (rsp_ready) state_d = S_IDLE;
      end
    endcase

    // Registered outputs track the state being entered so they align with it.
    rsp_valid_d = (state_d == S_RESP);
    dp_start_d  = (state_d == S_ISSUE);
    dp_ce_d     = (state_d == S_ISSUE) || (state_d == S_WAIT);
    busy_d      = (state_d != S_IDLE);
    if (state_d == S_ISSUE) dp_sel_d = (pass_d != '0);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      pass_q      <= '0;
      wait_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
      rsp_err_q   <= 1'b0;
      dp_ce_q     <= 1'b0;
      dp_start_q  <= 1'b0;
      dp_sel_q    <= 1'b0;
      dp_x_q      <= '0;
      dp_fb_q     <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      pass_q      <= pass_d;
      wait_q      <= wait_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_id_q    <= rsp_id_d;
      rsp_err_q   <= rsp_err_d;
      dp_ce_q     <= dp_ce_d;
      dp_start_q  <= dp_start_d;
      dp_sel_q    <= dp_sel_d;
      dp_x_q      <= dp_x_d;
      dp_fb_q     <= dp_fb_d;
      busy_q      <= busy_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_err   = rsp_err_q;
  assign dp_ce     = dp_ce_q;
  assign dp_start  = dp_start_q;
  assign dp_sel    = dp_sel_q;
  assign dp_x      = dp_x_q;
  assign dp_fb     = dp_fb_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_rsqrt_nr_job_scheduler.sv
// Directed bench for rsqrt_nr_job_scheduler: default instance plus a single-pass
// (ITERATION=0, PASS_LAT=2) instance, each with a simple datapath model.
module tb_rsqrt_nr_job_scheduler;

  localparam int unsigned WL   = 24;
  localparam int unsigned NREQ = 4;
  localparam int unsigned IDW  = 2;
  localparam int unsigned PL_A = 3;
  localparam int unsigned PL_B = 2;
  localparam logic [WL-1:0] Y_JUNK = 24'h5A5A5A;

  logic                CLK = 1'b0;
  logic                RST;

  logic [NREQ-1:0]     req_valid, req_ready;
  logic [NREQ*WL-1:0]  req_data;
  logic                rsp_valid, rsp_ready, rsp_err;
  logic [WL-1:0]       rsp_data;
  logic [IDW-1:0]      rsp_id;
  logic                dp_ce, dp_start, dp_sel, busy;
  logic [WL-1:0]       dp_x, dp_fb;
  logic [WL-1:0]       dp_y = Y_JUNK;

  logic [NREQ-1:0]     req_valid_b, req_ready_b;
  logic [NREQ*WL-1:0]  req_data_b;
  logic                rsp_valid_b, rsp_ready_b, rsp_err_b;
  logic [WL-1:0]       rsp_data_b;
  logic [IDW-1:0]      rsp_id_b;
  logic                dp_ce_b, dp_start_b, dp_sel_b, busy_b;
  logic [WL-1:0]       dp_x_b, dp_fb_b;
  logic [WL-1:0]       dp_y_b = Y_JUNK;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 CLK = ~CLK;

  rsqrt_nr_job_scheduler #(.WL(WL), .NREQ(NREQ), .IDW(IDW), .ITERATION(1), .PASS_LAT(PL_A)) u_dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_id(rsp_id), .rsp_err(rsp_err),
    .dp_ce(dp_ce), .dp_start(dp_start), .dp_sel(dp_sel),
    .dp_x(dp_x), .dp_fb(dp_fb), .dp_y(dp_y), .busy(busy)
  );

  rsqrt_nr_job_scheduler #(.WL(WL), .NREQ(NREQ), .IDW(IDW), .ITERATION(0), .PASS_LAT(PL_B)) u_dut_b (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid_b), .req_ready(req_ready_b), .req_data(req_data_b),
    .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready_b), .rsp_data(rsp_data_b),
    .rsp_id(rsp_id_b), .rsp_err(rsp_err_b),
    .dp_ce(dp_ce_b), .dp_start(dp_start_b), .dp_sel(dp_sel_b),
    .dp_x(dp_x_b), .dp_fb(dp_fb_b), .dp_y(dp_y_b), .busy(busy_b)
  );

  // Datapath model: result valid only in the cycle ending at the capture edge.
  // Seed pass returns the operand; feedback pass returns previous estimate minus one.
  always @(posedge CLK) begin
    if (dp_start) begin
      repeat (PL_A - 1) @(posedge CLK);
      #1 dp_y = dp_sel ? (dp_fb - 24'd1) : dp_x;
      @(posedge CLK);
      #1 dp_y = Y_JUNK;
    end
  end

  always @(posedge CLK) begin
    if (dp_start_b) begin
      repeat (PL_B - 1) @(posedge CLK);
      #1 dp_y_b = dp_x_b ^ 24'h00FFFF;
      @(posedge CLK);
      #1 dp_y_b = Y_JUNK;
    end
  end

  task automatic test_reset();
    logic [83:0] snap;
    RST = 1'b1;
    req_valid = 4'hF; req_data = '0; rsp_ready = 1'b1;
    req_valid_b = 4'hF; req_data_b = '0; rsp_ready_b = 1'b1;
    repeat (2) @(negedge CLK);
    #1;
    snap = {req_ready, rsp_valid, rsp_data, rsp_id, rsp_err, dp_ce, dp_start, dp_sel, dp_x, dp_fb, busy};
    n_tests++;
    if (snap !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got %h required 0", snap);
    end
    n_tests++;
    if ({req_ready_b, rsp_valid_b, busy_b, dp_ce_b, dp_start_b} !== '0) begin
      n_fail++; $display("FAIL reset_outputs_b: got %b required 0",
                         {req_ready_b, rsp_valid_b, busy_b, dp_ce_b, dp_start_b});
    end
    @(negedge CLK);
    RST = 1'b0; req_valid = '0; req_valid_b = '0;
    #1;
    n_tests++;
    if (busy !== 1'b0 || req_ready !== 4'h0) begin
      n_fail++; $display("FAIL idle_after_reset: busy=%b req_ready=%b required 0,0000", busy, req_ready);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0]    exp_id [5];
    logic [WL-1:0] exp_data;
    int n_grant, n_rsp, low_run, cyc;
    exp_id = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    n_grant = 0; n_rsp = 0; low_run = 0; cyc = 0;
    for (int i = 0; i < 4; i++) req_data[i*WL +: WL] = 24'h900000 + 24'(i) * 24'h100000;
    rsp_ready = 1'b1;
    while (n_rsp < 5 && cyc < 200) begin
      @(negedge CLK);
      req_valid = (n_grant < 5) ? 4'hF : 4'h0;
      #1; cyc++;
      if (req_ready !== 4'h0) begin
        n_tests++;
        if (n_grant >= 5) begin
          n_fail++; $display("FAIL rr_extra_grant: got req_ready=%b required 0000", req_ready);
        end else if (req_ready !== (4'b0001 << exp_id[n_grant]) || busy !== 1'b0) begin
          n_fail++; $display("FAIL rr_grant%0d: got req_ready=%b busy=%b required %b busy=0",
                             n_grant, req_ready, busy, 4'b0001 << exp_id[n_grant]);
        end
        n_grant++;
      end
      if (rsp_valid) begin
        exp_data = 24'h8FFFFF + 24'(exp_id[n_rsp]) * 24'h100000;
        n_tests++;
        if (rsp_id !== exp_id[n_rsp] || rsp_data !== exp_data || rsp_err !== 1'b0) begin
          n_fail++; $display("FAIL rr_rsp%0d: got id=%0d data=%h err=%b required id=%0d data=%h err=0",
                             n_rsp, rsp_id, rsp_data, rsp_err, exp_id[n_rsp], exp_data);
        end
        n_rsp++;
      end
      if (!busy) low_run++;
      else begin
        if (low_run != 0 && n_rsp > 0) begin
          n_tests++;
          if (low_run != 1) begin
            n_fail++; $display("FAIL rr_idle_gap: got %0d idle cycles required 1", low_run);
          end
        end
        low_run = 0;
      end
    end
    n_tests++;
    if (n_rsp < 5) begin
      n_fail++; $display("FAIL rr_timeout: got %0d responses required 5", n_rsp);
    end
  endtask

  task automatic test_backpressure();
    int cyc;
    bit rdy_bad, hold_bad;
    rdy_bad = 1'b0; hold_bad = 1'b0; cyc = 0;
    req_data[1*WL +: WL] = 24'hA00000;
    req_data[3*WL +: WL] = 24'hC00000;
    @(negedge CLK);
    rsp_ready = 1'b0; req_valid = 4'b1010;
    #1;
    n_tests++;
    if (req_ready !== 4'b0010) begin
      n_fail++; $display("FAIL bp_grant: got %b required 0010", req_ready);
    end
    do begin
      @(negedge CLK); req_valid = 4'b1000; #1; cyc++;
      if (req_ready !== 4'h0) rdy_bad = 1'b1;
    end while (!rsp_valid && cyc < 20);
    n_tests++;
    if (!rsp_valid || cyc != 9) begin
      n_fail++; $display("FAIL bp_latency: got rsp_valid=%b after %0d cycles required 1 after 9", rsp_valid, cyc);
    end
    for (int k = 0; k < 10; k++) begin
      @(negedge CLK); #1;
      if (rsp_valid !== 1'b1 || rsp_data !== 24'h9FFFFF || rsp_id !== 2'd1 ||
          rsp_err !== 1'b0 || req_ready !== 4'h0) hold_bad = 1'b1;
    end
    n_tests++;
    if (hold_bad) begin
      n_fail++; $display("FAIL bp_hold: got valid=%b data=%h id=%0d req_ready=%b required 1 9fffff 1 0000",
                         rsp_valid, rsp_data, rsp_id, req_ready);
    end
    n_tests++;
    if (rdy_bad) begin
      n_fail++; $display("FAIL bp_ready_busy: got req_ready high while busy required 0000");
    end
    @(negedge CLK); rsp_ready = 1'b1; #1;
    n_tests++;
    if (rsp_valid !== 1'b1) begin
      n_fail++; $display("FAIL bp_release_cycle: got rsp_valid=%b required 1", rsp_valid);
    end
    @(negedge CLK); rsp_ready = 1'b0; #1;
    n_tests++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 4'b1000) begin
      n_fail++; $display("FAIL bp_idle_after_release: got busy=%b valid=%b req_ready=%b required 0 0 1000",
                         busy, rsp_valid, req_ready);
    end
    @(negedge CLK); req_valid = 4'h0; rsp_ready = 1'b1; #1;
    n_tests++;
    if (dp_start !== 1'b1 || busy !== 1'b1) begin
      n_fail++; $display("FAIL bp_next_issue: got dp_start=%b busy=%b required 1 1", dp_start, busy);
    end
    cyc = 0;
    do begin @(negedge CLK); #1; cyc++; end while (!rsp_valid && cyc < 20);
    n_tests++;
    if (!rsp_valid || rsp_data !== 24'hBFFFFF || rsp_id !== 2'd3) begin
      n_fail++; $display("FAIL bp_next_rsp: got valid=%b data=%h id=%0d required 1 bfffff 3",
                         rsp_valid, rsp_data, rsp_id);
    end
  endtask

  task automatic test_unnorm();
    req_data[0*WL +: WL] = 24'h400000;
    rsp_ready = 1'b1;
    @(negedge CLK); req_valid = 4'b0001; #1;
    n_tests++;
    if (req_ready !== 4'b0001) begin
      n_fail++; $display("FAIL un_grant: got %b required 0001", req_ready);
    end
    @(negedge CLK); req_valid = 4'h0; #1;
    n_tests++;
    if (rsp_valid !== 1'b1 || rsp_data !== 24'hFFFFFF || rsp_err !== 1'b1 || rsp_id !== 2'd0 ||
        dp_start !== 1'b0 || dp_ce !== 1'b0) begin
      n_fail++; $display("FAIL un_rsp: got valid=%b data=%h err=%b id=%0d start=%b ce=%b required 1 ffffff 1 0 0 0",
                         rsp_valid, rsp_data, rsp_err, rsp_id, dp_start, dp_ce);
    end
    @(negedge CLK); #1;
    n_tests++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || dp_start !== 1'b0) begin
      n_fail++; $display("FAIL un_idle: got valid=%b busy=%b start=%b required 0 0 0", rsp_valid, busy, dp_start);
    end
  endtask

  task automatic test_single();
    logic [31:0]   start_mask, sel_bits;
    logic [WL-1:0] fb_at5;
    int cyc;
    bit rdy_extra;
    start_mask = '0; sel_bits = '0; fb_at5 = '0; cyc = 0; rdy_extra = 1'b0;
    req_data[2*WL +: WL] = 24'h800000;
    rsp_ready = 1'b1;
    @(negedge CLK); req_valid = 4'b0100; #1;
    n_tests++;
    if (req_ready !== 4'b0100) begin
      n_fail++; $display("FAIL single_grant: got %b required 0100", req_ready);
    end
    do begin
      @(negedge CLK); req_valid = 4'h0; #1; cyc++;
      if (dp_start) begin start_mask[cyc] = 1'b1; sel_bits[cyc] = dp_sel; end
      if (cyc == 5) fb_at5 = dp_fb;
      if (req_ready !== 4'h0) rdy_extra = 1'b1;
    end while (!rsp_valid && cyc < 20);
    n_tests++;
    if (start_mask !== 32'h22) begin
      n_fail++; $display("FAIL single_start_cycles: got %h required 00000022", start_mask);
    end
    n_tests++;
    if (sel_bits !== 32'h20) begin
      n_fail++; $display("FAIL single_sel: got %h required 00000020", sel_bits);
    end
    n_tests++;
    if (fb_at5 !== 24'h800000) begin
      n_fail++; $display("FAIL single_fb: got %h required 800000", fb_at5);
    end
    n_tests++;
    if (!rsp_valid || cyc != 9 || rsp_data !== 24'h7FFFFF || rsp_id !== 2'd2 || rsp_err !== 1'b0) begin
      n_fail++; $display("FAIL single_rsp: got valid=%b at %0d data=%h id=%0d err=%b required 1 at 9 7fffff 2 0",
                         rsp_valid, cyc, rsp_data, rsp_id, rsp_err);
    end
    n_tests++;
    if (rdy_extra) begin
      n_fail++; $display("FAIL single_ready_once: got req_ready high after accept required 0000");
    end
    @(negedge CLK); #1;
    n_tests++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0 || dp_ce !== 1'b0) begin
      n_fail++; $display("FAIL single_idle: got busy=%b valid=%b ce=%b required 0 0 0", busy, rsp_valid, dp_ce);
    end
  endtask

  task automatic test_reset_midjob();
    logic [83:0] snap;
    int cyc;
    bit spurious;
    spurious = 1'b0; cyc = 0;
    req_data[1*WL +: WL] = 24'h900000;
    rsp_ready = 1'b1;
    @(negedge CLK); req_valid = 4'b0010; #1;
    n_tests++;
    if (req_ready !== 4'b0010) begin
      n_fail++; $display("FAIL mid_grant: got %b required 0010", req_ready);
    end
    @(negedge CLK); req_valid = 4'h0;
    repeat (5) @(negedge CLK);
    #1;
    n_tests++;
    if (dp_sel !== 1'b1 || dp_start !== 1'b0 || dp_ce !== 1'b1) begin
      n_fail++; $display("FAIL mid_second_wait: got sel=%b start=%b ce=%b required 1 0 1", dp_sel, dp_start, dp_ce);
    end
    @(negedge CLK); RST = 1'b1;
    @(negedge CLK); RST = 1'b0; #1;
    snap = {req_ready, rsp_valid, rsp_data, rsp_id, rsp_err, dp_ce, dp_start, dp_sel, dp_x, dp_fb, busy};
    n_tests++;
    if (snap !== '0) begin
      n_fail++; $display("FAIL mid_reset_outputs: got %h required 0", snap);
    end
    for (int k = 0; k < 12; k++) begin
      @(negedge CLK); #1;
      if (rsp_valid || busy) spurious = 1'b1;
    end
    n_tests++;
    if (spurious) begin
      n_fail++; $display("FAIL mid_no_rsp: got activity after reset required none");
    end
    req_data[0*WL +: WL] = 24'hB00000;
    req_data[2*WL +: WL] = 24'hE00000;
    @(negedge CLK); req_valid = 4'b0101; #1;
    n_tests++;
    if (req_ready !== 4'b0001) begin
      n_fail++; $display("FAIL mid_ptr_reset: got %b required 0001", req_ready);
    end
    do begin
      @(negedge CLK); req_valid = 4'h0; #1; cyc++;
    end while (!rsp_valid && cyc < 20);
    n_tests++;
    if (!rsp_valid || cyc != 9 || rsp_data !== 24'hAFFFFF || rsp_id !== 2'd0) begin
      n_fail++; $display("FAIL mid_new_job: got valid=%b at %0d data=%h id=%0d required 1 at 9 afffff 0",
                         rsp_valid, cyc, rsp_data, rsp_id);
    end
  endtask

  task automatic test_iter0();
    int cyc, starts;
    bit sel_seen;
    cyc = 0; starts = 0; sel_seen = 1'b0;
    req_data_b[3*WL +: WL] = 24'hC00000;
    rsp_ready_b = 1'b1;
    @(negedge CLK); req_valid_b = 4'b1000; #1;
    n_tests++;
    if (req_ready_b !== 4'b1000) begin
      n_fail++; $display("FAIL it0_grant: got %b required 1000", req_ready_b);
    end
    do begin
      @(negedge CLK); req_valid_b = 4'h0; #1; cyc++;
      if (dp_start_b) starts++;
      if (dp_sel_b) sel_seen = 1'b1;
    end while (!rsp_valid_b && cyc < 20);
    n_tests++;
    if (starts != 1 || sel_seen) begin
      n_fail++; $display("FAIL it0_passes: got %0d starts sel_seen=%b required 1 starts sel_seen=0", starts, sel_seen);
    end
    n_tests++;
    if (!rsp_valid_b || cyc != 4 || rsp_data_b !== 24'hC0FFFF || rsp_id_b !== 2'd3 || rsp_err_b !== 1'b0) begin
      n_fail++; $display("FAIL it0_rsp: got valid=%b at %0d data=%h id=%0d err=%b required 1 at 4 c0ffff 3 0",
                         rsp_valid_b, cyc, rsp_data_b, rsp_id_b, rsp_err_b);
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_backpressure();
    test_unnorm();
    test_single();
    test_reset_midjob();
    test_iter0();
    repeat (2) @(negedge CLK);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within 200000 time units");
    $fatal(1);
  end

endmodule
